// File: rtl/id_decode_stage.sv
// ---------------------------------------------------------------------------
// id_decode_stage
//
// Instruction-decode pipeline stage that feeds the immediate extender. It
// accepts a fetched instruction and its PC over a valid/ready handshake. It
// slices out the register indices and the raw I/S/B/U/J immediate fields,
// and derives the 3-bit immediate-extension selector. A two-entry skid
// buffer sits between fetch and execute, so if_ready comes straight from a
// register.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an ex_illegal port is added. Unknown opcodes pass through
//               unchanged with ex_illegal = 1 and selector 7.
//   undefined : unknown opcodes are turned into a NOP (addi x0,x0,0)
//               with selector 1.
//
// Ports
//   clk, rst              clock and synchronous active-high reset
//   flush                 drop every buffered instruction (redirect)
//   if_valid/if_ready     fetch-side handshake (if_ready is registered)
//   if_pc, if_inst        presented PC and instruction word
//   ex_valid/ex_ready     execute-side handshake
//   ex_pc .. ex_funct7    decoded PC, opcode, register indices and functs
//   imm_*_data            raw immediate fields, before sign extension
//   imm_extended_control  immediate-extension selector
//   ex_illegal            unknown opcode flag (ILLEGAL_TRAP_EN only)
// ---------------------------------------------------------------------------
module id_decode_stage #(
   parameter int DATA_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 if_valid,
   output logic                 if_ready,
   input  logic [DATA_SIZE-1:0] if_pc,
   input  logic [DATA_SIZE-1:0] if_inst,
   output logic                 ex_valid,
   input  logic                 ex_ready,
   output logic [DATA_SIZE-1:0] ex_pc,
   output logic [6:0]           ex_opcode,
   output logic [4:0]           ex_rd_addr,
   output logic [4:0]           ex_rs1_addr,
   output logic [4:0]           ex_rs2_addr,
   output logic [2:0]           ex_funct3,
   output logic [6:0]           ex_funct7,
   output logic [11:0]          imm_i_data,
   output logic [11:0]          imm_s_data,
   output logic [11:0]          imm_b_data,
   output logic [19:0]          imm_u_data,
   output logic [19:0]          imm_j_data,
   output logic [2:0]           imm_extended_control
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic                 ex_illegal
`endif
);

   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

`ifndef ILLEGAL_TRAP_EN
   localparam logic [DATA_SIZE-1:0] NOP_INST = DATA_SIZE'(32'h0000_0013);
`endif

   typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

   buf_state_t state, state_next;

   logic                 dec_legal;
   logic [2:0]           dec_sel;
   logic [DATA_SIZE-1:0] dec_inst;

   logic                 load_main, load_skid, move_skid;
   logic                 accept, transfer;

   logic                 if_ready_q, ex_valid_q;
   logic [DATA_SIZE-1:0] main_pc, main_inst, skid_pc, skid_inst;
   logic [2:0]           main_sel, skid_sel;
`ifdef ILLEGAL_TRAP_EN
   logic                 main_ill, skid_ill;
`endif

   assign accept   = if_valid & if_ready_q;
   assign transfer = ex_valid_q & ex_ready;

   // Decode the selector from the opcode. Unknown opcodes either get flagged
   // or are rewritten to a NOP before they are stored in a slot.
   always_comb begin
      dec_legal = 1'b1;
      dec_sel   = 3'd7;
      dec_inst  = if_inst;
      case (if_inst[6:0])
         OPC_SYSTEM:                     dec_sel = 3'd0;
         OPC_LOAD, OPC_OPIMM, OPC_JALR:  dec_sel = 3'd1;
         OPC_STORE:                      dec_sel = 3'd2;
         OPC_BRANCH:                     dec_sel = 3'd3;
         OPC_LUI, OPC_AUIPC:             dec_sel = 3'd4;
         OPC_JAL:                        dec_sel = 3'd5;
         OPC_OP:                         dec_sel = 3'd7;
         default: begin
            dec_legal = 1'b0;
            dec_sel   = 3'd7;
         end
      endcase
`ifndef ILLEGAL_TRAP_EN
      if (!dec_legal) begin
         dec_inst = NOP_INST;
         dec_sel  = 3'd1;
      end
`endif
   end

   // Skid buffer control. When flush is high, every load is suppressed and
   // the buffer empties. FULL never sees an accept because if_ready is low.
   always_comb begin
      state_next = state;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      move_skid  = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_next = ONE;
               load_main  = 1'b1;
            end
         end
         ONE: begin
            if (accept && transfer) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_next = FULL;
               load_skid  = 1'b1;
            end else if (transfer) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (transfer) begin
               state_next = ONE;
               move_skid  = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
      if (flush) begin
         state_next = EMPTY;
         load_main  = 1'b0;
         load_skid  = 1'b0;
         move_skid  = 1'b0;
      end
   end

   // State and handshake registers. The handshake flags are computed from
   // the next state, so both outputs come directly from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         ex_valid_q <= 1'b0;
         if_ready_q <= 1'b1;
      end else begin
         state      <= state_next;
         ex_valid_q <= (state_next != EMPTY);
         if_ready_q <= (state_next != FULL);
      end
   end

   // Slot storage. The main slot only changes on a load or a skid move.
   // This keeps the ex_* outputs stable while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_pc   <= '0;
         main_inst <= '0;
         main_sel  <= 3'd7;
         skid_pc   <= '0;
         skid_inst <= '0;
         skid_sel  <= 3'd7;
`ifdef ILLEGAL_TRAP_EN
         main_ill  <= 1'b0;
         skid_ill  <= 1'b0;
`endif
      end else begin
         if (load_main) begin
            main_pc   <= if_pc;
            main_inst <= dec_inst;
            main_sel  <= dec_sel;
`ifdef ILLEGAL_TRAP_EN
            main_ill  <= ~dec_legal;
`endif
         end else if (move_skid) begin
            main_pc   <= skid_pc;
            main_inst <= skid_inst;
            main_sel  <= skid_sel;
`ifdef ILLEGAL_TRAP_EN
            main_ill  <= skid_ill;
`endif
         end
         if (load_skid) begin
            skid_pc   <= if_pc;
            skid_inst <= dec_inst;
            skid_sel  <= dec_sel;
`ifdef ILLEGAL_TRAP_EN
            skid_ill  <= ~dec_legal;
`endif
         end
      end
   end

   assign if_ready             = if_ready_q;
   assign ex_valid             = ex_valid_q;
   assign ex_pc                = main_pc;
   assign ex_opcode            = main_inst[6:0];
   assign ex_rd_addr           = main_inst[11:7];
   assign ex_rs1_addr          = main_inst[19:15];
   assign ex_rs2_addr          = main_inst[24:20];
   assign ex_funct3            = main_inst[14:12];
   assign ex_funct7            = main_inst[31:25];
   assign imm_i_data           = main_inst[31:20];
   assign imm_s_data           = {main_inst[31:25], main_inst[11:7]};
   assign imm_b_data           = {main_inst[31], main_inst[7], main_inst[30:25], main_inst[11:8]};
   assign imm_u_data           = main_inst[31:12];
   assign imm_j_data           = {main_inst[31], main_inst[19:12], main_inst[20], main_inst[30:21]};
   assign imm_extended_control = main_sel;
`ifdef ILLEGAL_TRAP_EN
   assign ex_illegal           = main_ill;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_id_decode_stage
//
// Testbench for id_decode_stage. A queue-based reference model tracks which
// instructions are in flight. Every cycle, the DUT outputs are compared with
// fields that are recomputed from the raw instruction at the head of the
// queue. Directed cases cover reset, known encodings, back-pressure, flush
// and illegal opcodes. Randomized traffic follows them. Honours
// ILLEGAL_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_id_decode_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst, flush, if_valid, if_ready, ex_valid, ex_ready;
   logic [31:0] if_pc, if_inst, ex_pc;
   logic [6:0]  ex_opcode, ex_funct7;
   logic [4:0]  ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
   logic [2:0]  ex_funct3, imm_extended_control;
   logic [11:0] imm_i_data, imm_s_data, imm_b_data;
   logic [19:0] imm_u_data, imm_j_data;
`ifdef ILLEGAL_TRAP_EN
   logic        ex_illegal;
`endif

   entry_t      model_q[$];
   logic [31:0] emerged_pc[$];
   int          checks = 0;
   int          failures = 0;
   int          xfer_count = 0;

   always #5 clk = ~clk;

   id_decode_stage #(.DATA_SIZE(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_opcode(ex_opcode), .ex_rd_addr(ex_rd_addr), .ex_rs1_addr(ex_rs1_addr),
      .ex_rs2_addr(ex_rs2_addr), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
      .imm_i_data(imm_i_data), .imm_s_data(imm_s_data), .imm_b_data(imm_b_data),
      .imm_u_data(imm_u_data), .imm_j_data(imm_j_data),
      .imm_extended_control(imm_extended_control)
`ifdef ILLEGAL_TRAP_EN
      , .ex_illegal(ex_illegal)
`endif
   );

   // Reference: is this opcode one of the recognised ones?
   function automatic bit refLegal(input logic [6:0] opc);
      return opc inside {7'b1110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                         7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
   endfunction

   // Reference: the selector taken from the opcode table.
   function automatic logic [2:0] refSel(input logic [6:0] opc);
      if (opc == 7'b1110011) return 3'd0;
      if (opc inside {7'b0000011, 7'b0010011, 7'b1100111}) return 3'd1;
      if (opc == 7'b0100011) return 3'd2;
      if (opc == 7'b1100011) return 3'd3;
      if (opc inside {7'b0110111, 7'b0010111}) return 3'd4;
      if (opc == 7'b1101111) return 3'd5;
`ifdef ILLEGAL_TRAP_EN
      return 3'd7;
`else
      return refLegal(opc) ? 3'd7 : 3'd1;
`endif
   endfunction

   // Reference: the instruction word the execute side should observe.
   function automatic logic [31:0] refInst(input logic [31:0] raw);
`ifdef ILLEGAL_TRAP_EN
      return raw;
`else
      return refLegal(raw[6:0]) ? raw : 32'h0000_0013;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output with the model state.
   task automatic verifyState();
      entry_t      e;
      logic [31:0] w;
      checkOutput("ex_valid", 32'(ex_valid), 32'(model_q.size() > 0));
      checkOutput("if_ready", 32'(if_ready), 32'(model_q.size() < 2));
      if (model_q.size() > 0) begin
         e = model_q[0];
         w = refInst(e.inst);
         checkOutput("ex_pc", ex_pc, e.pc);
         checkOutput("ex_opcode", 32'(ex_opcode), 32'(w[6:0]));
         checkOutput("ex_rd_addr", 32'(ex_rd_addr), 32'(w[11:7]));
         checkOutput("ex_rs1_addr", 32'(ex_rs1_addr), 32'(w[19:15]));
         checkOutput("ex_rs2_addr", 32'(ex_rs2_addr), 32'(w[24:20]));
         checkOutput("ex_funct3", 32'(ex_funct3), 32'(w[14:12]));
         checkOutput("ex_funct7", 32'(ex_funct7), 32'(w[31:25]));
         checkOutput("imm_i", 32'(imm_i_data), 32'(w[31:20]));
         checkOutput("imm_s", 32'(imm_s_data), 32'({w[31:25], w[11:7]}));
         checkOutput("imm_b", 32'(imm_b_data), 32'({w[31], w[7], w[30:25], w[11:8]}));
         checkOutput("imm_u", 32'(imm_u_data), 32'(w[31:12]));
         checkOutput("imm_j", 32'(imm_j_data), 32'({w[31], w[19:12], w[20], w[30:21]}));
         checkOutput("imm_sel", 32'(imm_extended_control), 32'(refSel(e.inst[6:0])));
`ifdef ILLEGAL_TRAP_EN
         checkOutput("ex_illegal", 32'(ex_illegal), 32'(!refLegal(e.inst[6:0])));
`endif
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then
   // check the outputs on the falling edge.
   task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                input logic rdy, input logic fl, input logic rs);
      bit     acc, xfer;
      entry_t e;
      if_valid = v;
      if_pc    = pc;
      if_inst  = inst;
      ex_ready = rdy;
      flush    = fl;
      rst      = rs;
      acc  = v && (model_q.size() < 2);
      xfer = rdy && (model_q.size() > 0);
      @(posedge clk);
      if (rs || fl) begin
         model_q.delete();
      end else begin
         if (xfer) begin
            e = model_q.pop_front();
            emerged_pc.push_back(e.pc);
            xfer_count++;
         end
         if (acc) begin
            e.pc   = pc;
            e.inst = inst;
            model_q.push_back(e);
         end
      end
      @(negedge clk);
      verifyState();
   endtask

   logic [31:0] stream_inst[4];
   logic [31:0] opc_pool[10];

   initial begin
      int          idx;
      int          start_x;
      bit          can;
      logic [31:0] r;
      logic [6:0]  opc;

      rst = 1'b1; flush = 1'b0; if_valid = 1'b1; ex_ready = 1'b1;
      if_pc = 32'h0; if_inst = 32'h0;

      // Reset with if_valid held high: nothing may be captured.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 32'h0000_0100, 32'h0010_0093, 1'b1, 1'b0, 1'b1);
         checkOutput("rst_ex_valid", 32'(ex_valid), 32'h0);
         checkOutput("rst_if_ready", 32'(if_ready), 32'h1);
         checkOutput("rst_pc", ex_pc, 32'h0);
         checkOutput("rst_imm_i", 32'(imm_i_data), 32'h0);
         checkOutput("rst_sel", 32'(imm_extended_control), 32'h7);
`ifdef ILLEGAL_TRAP_EN
         checkOutput("rst_illegal", 32'(ex_illegal), 32'h0);
`endif
      end

      // Known encodings with ex_ready held high.
      applyStimulus(1'b1, 32'h0000_0200, 32'hFE51_2E23, 1'b1, 1'b0, 1'b0);
      checkOutput("sw_valid", 32'(ex_valid), 32'h1);
      checkOutput("sw_imm_s", 32'(imm_s_data), 32'hFFC);
      checkOutput("sw_sel", 32'(imm_extended_control), 32'h2);
      checkOutput("sw_rs2", 32'(ex_rs2_addr), 32'h5);
      checkOutput("sw_rs1", 32'(ex_rs1_addr), 32'h2);
      applyStimulus(1'b1, 32'h0000_0204, 32'h0010_00EF, 1'b1, 1'b0, 1'b0);
      checkOutput("jal_imm_j", 32'(imm_j_data), 32'h00400);
      checkOutput("jal_sel", 32'(imm_extended_control), 32'h5);
      applyStimulus(1'b1, 32'h0000_0208, 32'hFE00_0FE3, 1'b1, 1'b0, 1'b0);
      checkOutput("beq_imm_b", 32'(imm_b_data), 32'hFFF);
      checkOutput("beq_sel", 32'(imm_extended_control), 32'h3);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Back-pressure: four instructions streamed, ex_ready low at first.
      stream_inst[0] = 32'h0050_0113;
      stream_inst[1] = 32'h0020_81B3;
      stream_inst[2] = 32'h1234_5237;
      stream_inst[3] = 32'h0041_2283;
      emerged_pc.delete();
      start_x = xfer_count;
      idx = 0;
      for (int c = 0; c < 40 && (idx < 4 || model_q.size() > 0); c++) begin
         can = (model_q.size() < 2);
         applyStimulus(idx < 4, 32'h1000 + 32'(idx) * 4, (idx < 4) ? stream_inst[idx] : 32'h0,
                       c >= 4, 1'b0, 1'b0);
         if (idx < 4 && can) idx++;
         if (c == 2) begin
            checkOutput("bp_if_ready_low", 32'(if_ready), 32'h0);
            checkOutput("bp_hold_first", ex_pc, 32'h1000);
         end
      end
      checkOutput("stream_accepted", 32'(idx), 32'h4);
      checkOutput("stream_emerged", 32'(xfer_count - start_x), 32'h4);
      for (int i = 0; i < 4; i++)
         checkOutput("stream_order", (i < emerged_pc.size()) ? emerged_pc[i] : 32'hDEAD, 32'h1000 + 32'(i) * 4);

      // Flush while FULL, with an instruction also on offer.
      applyStimulus(1'b1, 32'h2000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h2004, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_flush_full", 32'(if_ready), 32'h0);
      applyStimulus(1'b1, 32'h2008, 32'h0000_0093, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_ex_valid", 32'(ex_valid), 32'h0);
      checkOutput("flush_if_ready", 32'(if_ready), 32'h1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("flush_dropped", 32'(ex_valid), 32'h0);

      // Illegal opcode 1111111.
      applyStimulus(1'b1, 32'h3000, 32'hABCD_E07F, 1'b1, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      checkOutput("ill_flag", 32'(ex_illegal), 32'h1);
      checkOutput("ill_sel", 32'(imm_extended_control), 32'h7);
      checkOutput("ill_opcode", 32'(ex_opcode), 32'h7F);
`else
      checkOutput("nop_sel", 32'(imm_extended_control), 32'h1);
      checkOutput("nop_opcode", 32'(ex_opcode), 32'h13);
      checkOutput("nop_rd", 32'(ex_rd_addr), 32'h0);
      checkOutput("nop_imm_i", 32'(imm_i_data), 32'h0);
`endif

      // Randomized traffic: mixed opcodes, back-pressure, flushes and resets.
      opc_pool = '{32'h73, 32'h03, 32'h13, 32'h67, 32'h23, 32'h63, 32'h37, 32'h17, 32'h6F, 32'h33};
      for (int c = 0; c < 400; c++) begin
         r   = $urandom();
         opc = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : opc_pool[$urandom_range(0, 9)][6:0];
         applyStimulus($urandom_range(0, 3) != 0, $urandom(), {r[31:7], opc},
                       $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0,
                       $urandom_range(0, 63) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
